// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the configurable UART transmitter.
//   - parity mode constants (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - transmitter FSM state encoding
//   - calc_bps_cnt(): clock cycles per bit period, evaluated at elaboration
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_t;

  // Cycles per bit; the fractional part is truncated, so the real baud rate
  // is slightly above the nominal one.
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO.
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset; flushes all entries
//   push   in   write wdata (ignored while full)
//   wdata  in   WIDTH-bit write data
//   pop    in   discard the head entry (ignored while empty)
//   rdata  out  head entry, valid whenever empty is low
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//   level  out  registered entry count, 0..DEPTH
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with configurable data width, parity and
// stop bits, fed through a small valid/ready input FIFO. LSB first.
//   sys_clk       in   system clock, rising edge
//   sys_rst       in   synchronous active-high reset; abandons any frame
//   tx_valid      in   producer offers tx_data
//   tx_data       in   DATA_BITS-bit word
//   tx_ready      out  FIFO can take a word (low during reset)
//   uart_txd      out  registered serial line, idle high
//   uart_tx_busy  out  registered, high while a frame is on the line
//   fifo_level    out  words queued, excluding the one being sent
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..8");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (BPS_CNT < 2) begin : g_bad_baud
    $error("uart_tx_cfg: CLK_FREQ/UART_BPS must be at least 2");
  end

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 par_load;

  tx_state_t            state,     state_next;
  logic [CNT_W-1:0]     bps_cnt,   cnt_next;
  logic [2:0]           bit_idx,   bit_next;
  logic [DATA_BITS-1:0] shift,     shift_next;
  logic                 par_bit,   par_next;
  logic                 txd_next;
  logic                 busy_next;
  logic                 bit_end;

  assign tx_ready = !sys_rst && !fifo_full;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (tx_valid && tx_ready),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Parity is fixed when the word leaves the FIFO, not recomputed from the
  // shift register (which is destroyed as the bits go out).
  assign par_load = (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
  assign bit_end  = (bps_cnt == CNT_W'(BPS_CNT - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_next = state;
    cnt_next   = (state == ST_IDLE || bit_end) ? '0 : bps_cnt + CNT_W'(1);
    bit_next   = bit_idx;
    shift_next = shift;
    par_next   = par_bit;
    fifo_pop   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_START;
          shift_next = fifo_rdata;
          par_next   = par_load;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_next = shift >> 1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          state_next = ST_STOP;
          bit_next   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            bit_next = '0;
            // Chain straight into the next start bit: no idle cycle between frames.
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              state_next = ST_START;
              shift_next = fifo_rdata;
              par_next   = par_load;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // The line level is derived from the upcoming state so that uart_txd can
    // be a plain register yet change on the same edge as the state.
    case (state_next)
      ST_START: txd_next = 1'b0;
      ST_DATA:  txd_next = shift_next[0];
      ST_PAR:   txd_next = par_next;
      default:  txd_next = 1'b1;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      bps_cnt      <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
    end else begin
      state        <= state_next;
      bps_cnt      <= cnt_next;
      bit_idx      <= bit_next;
      shift        <= shift_next;
      par_bit      <= par_next;
      uart_txd     <= txd_next;
      uart_tx_busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: three transmitter instances (8N1, 7E1, 8O2) on one clock,
// checked every cycle against a frame-level model, plus hand-computed
// literal expectations for the directed scenarios.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1000000;
  localparam int UART_BPS = 100000;
  localparam int BPS      = 10;
  localparam int DEPTH    = 4;
  localparam int NCH      = 3;
  localparam int DB [NCH] = '{8, 7, 8};
  localparam int PM [NCH] = '{PAR_NONE, PAR_EVEN, PAR_ODD};
  localparam int SB [NCH] = '{1, 1, 2};

  logic           clk = 1'b0;
  logic [NCH-1:0] rst;
  logic [NCH-1:0] valid;
  logic [7:0]     data [NCH];
  wire  [NCH-1:0] txd_w;
  wire  [NCH-1:0] busy_w;
  wire  [NCH-1:0] ready_w;
  wire  [2:0]     level_w [NCH];

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < NCH; g++) begin : g_dut
    uart_tx_cfg #(
      .CLK_FREQ   (CLK_FREQ),
      .UART_BPS   (UART_BPS),
      .DATA_BITS  (DB[g]),
      .PARITY     (PM[g]),
      .STOP_BITS  (SB[g]),
      .FIFO_DEPTH (DEPTH)
    ) u_dut (
      .sys_clk      (clk),
      .sys_rst      (rst[g]),
      .tx_valid     (valid[g]),
      .tx_data      (data[g][DB[g]-1:0]),
      .tx_ready     (ready_w[g]),
      .uart_txd     (txd_w[g]),
      .uart_tx_busy (busy_w[g]),
      .fifo_level   (level_w[g])
    );
  end

  // ---------------- behavioural model ----------------
  int q [NCH][$];
  bit m_active [NCH];
  int m_pos    [NCH];
  int m_cur    [NCH];
  bit m_acc    [NCH];
  int edge_cnt;
  int n_checks;
  int n_errors;

  function automatic int frame_len(input int ch);
    return (1 + DB[ch] + ((PM[ch] != PAR_NONE) ? 1 : 0) + SB[ch]) * BPS;
  endfunction

  // Line level the specification demands for the current model position.
  function automatic int exp_line(input int ch);
    int idx;
    int ones;
    if (!m_active[ch]) return 1;
    idx = m_pos[ch] / BPS;
    if (idx == 0) return 0;
    if (idx <= DB[ch]) return (m_cur[ch] >> (idx - 1)) & 1;
    if (PM[ch] != PAR_NONE && idx == DB[ch] + 1) begin
      ones = $countones(m_cur[ch]);
      return (PM[ch] == PAR_EVEN) ? (ones % 2) : (1 - ones % 2);
    end
    return 1;
  endfunction

  function automatic int exp_ready(input int ch);
    return (!rst[ch] && q[ch].size() < DEPTH) ? 1 : 0;
  endfunction

  task automatic model_update();
    for (int ch = 0; ch < NCH; ch++) begin
      m_acc[ch] = valid[ch] && !rst[ch] && (q[ch].size() < DEPTH);
      if (rst[ch]) begin
        q[ch].delete();
        m_active[ch] = 1'b0;
        m_pos[ch]    = 0;
      end else begin
        if (m_active[ch]) begin
          m_pos[ch]++;
          if (m_pos[ch] == frame_len(ch)) m_active[ch] = 1'b0;
        end
        if (!m_active[ch] && q[ch].size() > 0) begin
          m_cur[ch]    = q[ch].pop_front();
          m_active[ch] = 1'b1;
          m_pos[ch]    = 0;
        end
        if (m_acc[ch]) q[ch].push_back(int'(data[ch]) & ((1 << DB[ch]) - 1));
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic compare_all();
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("ch%0d_txd", ch),   32'(txd_w[ch]),   exp_line(ch));
      check($sformatf("ch%0d_busy", ch),  32'(busy_w[ch]),  32'(m_active[ch]));
      check($sformatf("ch%0d_level", ch), 32'(level_w[ch]), q[ch].size());
      check($sformatf("ch%0d_ready", ch), 32'(ready_w[ch]), exp_ready(ch));
    end
  endtask

  // One clock: model advances on the edge, outputs compared half a cycle later.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    edge_cnt++;
  endtask

  // Push one word into an idle channel and pin the line against a literal
  // bit pattern (one entry per bit period, last entry is the idle level).
  task automatic literal_frame(input int ch, input logic [7:0] w, input int pat [12],
                               input int nbits, input int frame_cycles);
    int busy_cnt;
    int cyc;
    valid[ch] = 1'b1;
    data[ch]  = w;
    step();
    valid[ch] = 1'b0;
    check($sformatf("ch%0d_idle_before_start", ch), 32'(txd_w[ch]), 1);
    busy_cnt = 0;
    for (int c = 1; c <= frame_cycles + 10; c++) begin
      step();
      cyc = c - 1;
      if (c == 1) begin
        check($sformatf("ch%0d_start_fall", ch), 32'(txd_w[ch]), 0);
        check($sformatf("ch%0d_busy_rise", ch), 32'(busy_w[ch]), 1);
      end
      if (busy_w[ch]) busy_cnt++;
      if (cyc % BPS == BPS / 2 && cyc / BPS < nbits)
        check($sformatf("ch%0d_bit%0d", ch, cyc / BPS), 32'(txd_w[ch]), pat[cyc / BPS]);
    end
    check($sformatf("ch%0d_busy_cycles", ch), busy_cnt, frame_cycles);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (c < budget && (busy_w != '0 || level_w[0] != 0 || level_w[1] != 0 || level_w[2] != 0)) begin
      step();
      c++;
    end
    check("drain_timeout", (c < budget) ? 1 : 0, 1);
  endtask

  int w [6];
  int acc_edge [6];
  int exp_acc [6] = '{0, 1, 2, 3, 4, 102};
  int idx;
  int start;
  int e;
  int fall;
  int lows;

  initial begin
    rst   = '1;
    valid = '0;
    for (int ch = 0; ch < NCH; ch++) data[ch] = '0;
    edge_cnt = 0;
    n_checks = 0;
    n_errors = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_active[ch] = 1'b0;
      m_pos[ch]    = 0;
      m_cur[ch]    = 0;
      m_acc[ch]    = 1'b0;
    end

    // Reset state.
    repeat (3) step();
    check("reset_txd",   32'(txd_w[0]),   1);
    check("reset_busy",  32'(busy_w[0]),  0);
    check("reset_level", 32'(level_w[0]), 0);
    check("reset_ready", 32'(ready_w[0]), 0);
    rst = '0;
    step();
    check("ready_after_reset", 32'(ready_w[0]), 1);

    // Directed single frames.
    literal_frame(0, 8'h55, '{0,1,0,1,0,1,0,1,0,1,1,1}, 11, 100);
    literal_frame(1, 8'h41, '{0,1,0,0,0,0,0,1,0,1,1,1}, 11, 100);
    literal_frame(2, 8'h00, '{0,0,0,0,0,0,0,0,0,1,1,1}, 12, 120);

    // FIFO fill with tx_valid held high.
    for (int i = 0; i < 6; i++) w[i] = $urandom_range(0, 255);
    start    = edge_cnt;
    idx      = 0;
    valid[0] = 1'b1;
    data[0]  = w[0][7:0];
    for (int c = 0; c < 300 && idx < 6; c++) begin
      e = edge_cnt - start;
      step();
      if (m_acc[0]) begin
        acc_edge[idx] = e;
        idx++;
        if (idx < 6) data[0] = w[idx][7:0];
      end
    end
    valid[0] = 1'b0;
    check("fifo_all_accepted", idx, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("fifo_accept_edge_w%0d", i), acc_edge[i], exp_acc[i]);
    fall = -1;
    for (int c = 0; c < 800 && fall < 0; c++) begin
      e = edge_cnt - start;
      step();
      if (!busy_w[0]) fall = e;
    end
    check("fifo_six_frames_end", fall, 601);

    // Reset during data bit 3 with two words queued.
    start    = edge_cnt;
    valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data[0] = 8'($urandom_range(0, 255));
      step();
    end
    valid[0] = 1'b0;
    check("rst_test_level_before", 32'(level_w[0]), 2);
    while (edge_cnt - start < 46) step();
    rst[0] = 1'b1;
    step();
    check("rst_mid_txd",   32'(txd_w[0]),   1);
    check("rst_mid_level", 32'(level_w[0]), 0);
    check("rst_mid_busy",  32'(busy_w[0]),  0);
    rst[0] = 1'b0;
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (txd_w[0] == 1'b0) lows++;
    end
    check("rst_no_restart", lows, 0);

    // Push and pop on the same STOP-to-START edge.
    start    = edge_cnt;
    valid[0] = 1'b1;
    data[0]  = 8'hA5;
    step();
    data[0]  = 8'h3C;
    step();
    valid[0] = 1'b0;
    while (edge_cnt - start < 101) step();
    check("same_edge_level_before", 32'(level_w[0]), 1);
    valid[0] = 1'b1;
    data[0]  = 8'hC3;
    step();
    valid[0] = 1'b0;
    check("same_edge_accepted",    32'(m_acc[0]),  1);
    check("same_edge_level_after", 32'(level_w[0]), 1);
    check("same_edge_busy",        32'(busy_w[0]),  1);
    wait_idle(600);

    // Randomised traffic with occasional resets on all three channels.
    for (int c = 0; c < 4000; c++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        valid[ch] = ($urandom_range(0, 3) == 0);
        data[ch]  = 8'($urandom);
        rst[ch]   = ($urandom_range(0, 599) == 0);
      end
      step();
    end
    valid = '0;
    rst   = '0;
    wait_idle(1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter; successor to the fixed 8N1 transmitter. Adds configurable data width, parity and stop bits, plus a small input FIFO with a valid/ready handshake so producers can queue words. Transmits LSB first at a fixed baud rate derived from the system clock. Sits between a byte producer (command/response logic) and the board TX pin.

## Interface
- CLK_FREQ, 50000000: system clock frequency in Hz.
- UART_BPS, 115200: baud rate.
- DATA_BITS, 8: data bits per frame, legal range 5..8.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries. Must be a power of 2 and ≥2.

- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- tx_valid  in  1  producer offers tx_data.
- tx_data  in  DATA_BITS  word to send.
- tx_ready  out  1  FIFO can accept a word. A word is accepted on a rising edge where tx_valid && tx_ready.
- uart_txd  out  1  serial line, idle high, registered.
- uart_tx_busy  out  1  a frame is in progress (FSM not IDLE), registered.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words queued, not counting the word being transmitted.

## Operation
- BPS_CNT = CLK_FREQ/UART_BPS, with integer truncation. Every bit period is exactly BPS_CNT cycles.
- Bit counter width is $clog2(BPS_CNT); it counts 0..BPS_CNT-1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START when the FIFO is non-empty. The same edge pops the head word into the shift register.
  - START -> DATA after 1 bit period.
  - DATA -> PAR (if PARITY != 0) or STOP, after DATA_BITS bit periods.
  - PAR -> STOP after 1 bit period.
  - STOP -> START (pop) if the FIFO is non-empty on the final cycle of the last stop bit; otherwise STOP -> IDLE.
- Line levels:
  - START: 0.
  - DATA: shift register bit 0, LSB first.
  - PAR: for even mode, the XOR-reduction of the data; for odd mode, its inverse. The parity is computed from the word at pop time.
  - STOP and IDLE: 1.
- tx_ready is low while sys_rst is asserted; otherwise tx_ready = !full.
- Push and pop on the same edge leave fifo_level unchanged.
- A push is never accepted when full; there is no overflow path.
- Reset mid-frame:
  - The frame is abandoned, the FIFO is flushed and the FSM returns to IDLE.
  - uart_txd = 1 from the edge on which reset is sampled.
  - No partial frame resumes after reset.

## Timing
- Reset values: uart_txd = 1, uart_tx_busy = 0, fifo_level = 0, tx_ready = 0 during reset and 1 on the first cycle after.
- Latency from idle: a word accepted at edge N, with the FIFO empty and the FSM in IDLE, is popped at edge N+1.
  - At edge N+1, uart_txd falls and uart_tx_busy rises.
  - fifo_level reads 1 for exactly one cycle.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × BPS_CNT cycles.
  - uart_tx_busy stays high for the whole frame.
  - uart_tx_busy falls on the edge following the last stop-bit cycle, unless a new frame starts.
- Back-to-back frames have zero idle cycles: the next start bit begins on the cycle after the last stop-bit cycle.
- tx_ready deasserts on the edge the FIFO becomes full. It reasserts on the edge of the next pop.

## Structure
- Package uart_pkg holds:
  - parity mode constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2;
  - the FSM state encoding;
  - the elaboration-time function computing BPS_CNT.
- Sub-module uart_tx_fifo: synchronous FIFO, DATA_BITS wide and FIFO_DEPTH deep, with a registered level counter and full/empty outputs. It is reused later by the receiver path.
- Top level contains the FSM, the bit-period counter, the data-bit counter, the shift register and the registered uart_txd.
- Illegal parameter values stop elaboration with an error.

## Test plan
Use CLK_FREQ = 1000000 and UART_BPS = 100000, so BPS_CNT = 10.
- 8N1, push 0x55 while idle:
  - uart_txd falls 1 cycle after acceptance.
  - Line shows 0,1,0,1,0,1,0,1,0,1,1, each level held 10 cycles.
  - uart_tx_busy is high for exactly 100 cycles.
- DATA_BITS = 7, even parity, push 0x41: line shows start 0, bits 1,0,0,0,0,0,1, parity 0, stop 1. Frame lasts 100 cycles.
- 8 data bits, odd parity, 2 stop bits, push 0x00: parity bit 1, stop high for 20 cycles, frame 120 cycles.
- FIFO_DEPTH = 4, tx_valid held high with words w0..w5:
  - w0..w4 are accepted on consecutive cycles, then tx_ready goes low.
  - w5 is accepted on the edge after w1 is popped.
  - All six frames are sent with zero gap between frames.
- Assert sys_rst for 1 cycle during data bit 3 with 2 words queued:
  - uart_txd = 1 and fifo_level = 0 after the reset edge.
  - uart_tx_busy = 0, and no further start bit appears.
- Push and pop on the same edge: queue 1 word, then push a new one on the exact STOP-to-START pop edge. fifo_level stays 1.
